// File: rtl/result_writeback_if.sv
// rtl/result_writeback_if.sv - accumulator-to-unified-buffer writeback bus bundle
interface result_writeback_if;
    logic         start;
    logic [7:0]   base_addr;
    logic [4:0]   row_count;
    logic [4:0]   shift;
    logic         acc_empty;
    logic         acc_rd_en;
    logic [319:0] acc_dout;
    logic         ub_wea;
    logic [7:0]   ub_addra;
    logic [127:0] ub_dina;
    logic         busy;
    logic         done;

    modport slave (
        input  start, base_addr, row_count, shift, acc_empty, acc_dout,
        output acc_rd_en, ub_wea, ub_addra, ub_dina, busy, done
    );

    modport master (
        output start, base_addr, row_count, shift, acc_empty, acc_dout,
        input  acc_rd_en, ub_wea, ub_addra, ub_dina, busy, done
    );
endinterface

// File: rtl/result_writeback.sv
// rtl/result_writeback.sv - drains accumulator rows, quantizes to int8, writes unified buffer (optional WB_ROUND_EN)
module result_writeback (
    input  logic                clk,
    input  logic                reset_n,
    result_writeback_if.slave   wb
);

    localparam int LANES     = 16;
    localparam int ACC_W     = 20;
    localparam int OUT_W     = 8;
    localparam int MAX_ROWS  = 16;
    localparam int MAX_SHIFT = 19;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [7:0]     addr_q;
    logic [4:0]     count_q;
    logic [4:0]     shift_q;
    logic [127:0]   row_q;
    logic [127:0]   row_d;
    logic [4:0]     count_clamped;
    logic [4:0]     shift_clamped;

    // One lane: widen to 21 bits so the rounding bias can never overflow,
    // shift arithmetically, then saturate to the signed int8 range.
    function automatic logic [OUT_W-1:0] quant_lane(
        input logic signed [ACC_W-1:0] lane,
        input logic        [4:0]       sh
    );
        logic signed [ACC_W:0] wide;
        logic signed [ACC_W:0] shifted;
        wide = {lane[ACC_W-1], lane};
`ifdef WB_ROUND_EN
        if (sh != 5'd0) begin
            wide = wide + (21'sd1 <<< (sh - 5'd1));
        end
`endif
        shifted = wide >>> sh;
        if (shifted > 21'sd127) begin
            return 8'h7F;
        end else if (shifted < -21'sd128) begin
            return 8'h80;
        end else begin
            return shifted[OUT_W-1:0];
        end
    endfunction

    // Clamp the sampled parameters to the supported ranges.
    always_comb begin
        count_clamped = (wb.row_count > 5'(MAX_ROWS))  ? 5'(MAX_ROWS)  : wb.row_count;
        shift_clamped = (wb.shift     > 5'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : wb.shift;
    end

    // Quantize every lane of the current accumulator row with the latched shift.
    always_comb begin
        row_d = '0;
        for (int i = 0; i < LANES; i++) begin
            row_d[OUT_W*i +: OUT_W] = quant_lane(wb.acc_dout[ACC_W*i +: ACC_W], shift_q);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one RD/CAP/WR round per row, RD stalls on an empty FIFO.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wb.start) begin
                    state_d = (wb.row_count == 5'd0) ? FIN : RD;
                end
            end
            RD: begin
                if (!wb.acc_empty) begin
                    state_d = CAP;
                end
            end
            CAP: state_d = WR;
            WR:  state_d = (count_q == 5'd1) ? FIN : RD;
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Drain parameters: latched only from IDLE so a start while busy is ignored;
    // address and remaining count advance once per completed write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q  <= 8'd0;
            count_q <= 5'd0;
            shift_q <= 5'd0;
        end else if (state_q == IDLE && wb.start) begin
            addr_q  <= wb.base_addr;
            count_q <= count_clamped;
            shift_q <= shift_clamped;
        end else if (state_q == WR) begin
            addr_q  <= addr_q + 8'd1;
            count_q <= count_q - 5'd1;
        end
    end

    // Quantized row register, loaded in CAP when the popped row is on acc_dout.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row_q <= '0;
        end else if (state_q == CAP) begin
            row_q <= row_d;
        end
    end

    // Outputs decode from the state; gating with reset_n keeps strobes quiet
    // while reset is held, before the first clock edge has cleared the state.
    always_comb begin
        wb.acc_rd_en = reset_n && (state_q == RD) && !wb.acc_empty;
        wb.ub_wea    = reset_n && (state_q == WR);
        wb.ub_addra  = reset_n ? addr_q : 8'd0;
        wb.ub_dina   = reset_n ? row_q  : 128'd0;
        wb.busy      = reset_n && (state_q != IDLE);
        wb.done      = reset_n && (state_q == FIN);
    end

endmodule

// File: doc/result_writeback.md
RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
REQ-001 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have port start  input  1  one-cycle pulse; begins a drain when idle.
REQ-004 SHALL have port base_addr  input  8  first unified-buffer row address, sampled with start.
REQ-005 SHALL have port row_count  input  5  rows to drain (0..16), sampled with start.
REQ-006 SHALL have port shift  input  5  arithmetic right-shift amount for quantization, sampled with start.
REQ-007 SHALL have port acc_empty  input  1  accumulator FIFO has no row available.
REQ-008 SHALL have port acc_rd_en  output  1  pop one 320-bit row from the accumulator FIFO.
REQ-009 SHALL have port acc_dout  input  320  accumulator row, 16 signed 20-bit lanes, valid the cycle after acc_rd_en.
REQ-010 SHALL have port ub_wea  output  1  unified-buffer write enable.
REQ-011 SHALL have port ub_addra  output  8  unified-buffer write address.
REQ-012 SHALL have port ub_dina  output  128  unified-buffer write data, 16 signed 8-bit lanes.
REQ-013 SHALL have ports busy and done  output  1 each  busy: drain in progress; done: one-cycle completion pulse.

Function
REQ-014 SHALL implement FSM states IDLE, RD, CAP, WR, FIN.
REQ-015 IDLE: start=1 SHALL latch base_addr, shift (values >19 clamped to 19) and row_count (values >16 clamped to 16), then go to RD; row_count=0 SHALL go directly to FIN.
REQ-016 RD: acc_rd_en SHALL equal !acc_empty; acc_empty=1 SHALL hold RD (stall, no pop); otherwise next state CAP.
REQ-017 CAP: SHALL register the quantized row from acc_dout; next state WR.
REQ-018 WR: ub_wea=1, ub_addra=current address, ub_dina=registered row for exactly one cycle; then address increments mod 256 (255 wraps to 0), remaining count decrements; next state RD if rows remain, else FIN.
REQ-019 FIN: done=1 for one cycle; next state IDLE.
REQ-020 busy SHALL be 1 in RD, CAP, WR, FIN and 0 in IDLE.
REQ-021 Lane i (i=0..15) SHALL take acc_dout[20i+19:20i] as signed, arithmetic-shift right by latched shift, saturate to [-128,127], and drive ub_dina[8i+7:8i].
REQ-022 Unstalled row cost SHALL be 3 cycles (RD, CAP, WR); start-to-done for N>=1 rows with no stalls SHALL be 3N+1 cycles.
REQ-023 start while busy SHALL be ignored with no effect on latched parameters.
REQ-024 acc_rd_en and ub_wea SHALL never be asserted in the same cycle.

Reset
REQ-025 reset_n=0 at a clock edge SHALL force IDLE, clear the latched address, count and shift, and clear registered data.
REQ-026 During and after reset, acc_rd_en, ub_wea, busy, done SHALL be 0, ub_addra 0, ub_dina 0.
REQ-027 Reset mid-drain SHALL abort without any further write or pop; a write in progress on the reset edge SHALL not be repeated.

Configuration
REQ-028 Macro WB_ROUND_EN SHALL select rounding.
REQ-029 With WB_ROUND_EN defined and shift>0: add 2^(shift-1) to each lane in 21-bit signed arithmetic before shifting (round half up), then saturate.
REQ-030 Without WB_ROUND_EN: truncating arithmetic shift (floor) only; shift=0 behaviour identical in both builds.

Verification
REQ-031 start, base_addr=0x10, row_count=2, shift=0, lanes = 5 and -3 -> writes at 0x10, 0x11 with bytes 0x05/0xFD; done 7 cycles after start.
REQ-032 shift=4, lane=0x00FFF (4095), lane=0xFFF00 (-256) -> bytes 0x7F (saturate 255->127) and 0xF0 (-16).
REQ-033 base_addr=0xFF, row_count=2 -> writes to 0xFF then 0x00.
REQ-034 acc_empty held 1 for 5 cycles in RD -> acc_rd_en stays 0, no write, drain completes after acc_empty drops; row_count=0 -> done next cycle, no writes.
REQ-035 reset_n=0 during CAP of row 1 of 4 -> no further ub_wea/acc_rd_en, busy=0; new start afterwards completes normally.
REQ-036 shift=1, lane=3: WB_ROUND_EN build -> 0x02; default build -> 0x01; lane=-3: rounded -> 0xFF (-1), truncated -> 0xFE (-2).
